// File: rtl/mips32_decode_if.sv
// Decode-stage bundle: fetch handshake, register-file read port, write-back
// retire port and the ID/EX output register towards execute.
interface mips32_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  sr1;
  logic [4:0]  sr2;
  logic [31:0] rddata1;
  logic [31:0] rddata2;
  logic        wb_valid;
  logic [4:0]  wb_dr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_op;
  logic [5:0]  out_funct;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_imm;
  logic [4:0]  out_dr;
  logic        out_we;
  logic [15:0] stall_cnt;

  modport master (
    output in_valid, instr, rddata1, rddata2, wb_valid, wb_dr, out_ready,
    input  in_ready, sr1, sr2, out_valid, out_op, out_funct, out_a, out_b,
           out_imm, out_dr, out_we, stall_cnt
  );

  modport slave (
    input  in_valid, instr, rddata1, rddata2, wb_valid, wb_dr, out_ready,
    output in_ready, sr1, sr2, out_valid, out_op, out_funct, out_a, out_b,
           out_imm, out_dr, out_we, stall_cnt
  );
endinterface

// File: rtl/mips32_decode.sv
// MIPS32 decode stage: classifies the instruction, holds issue on scoreboard
// hazards (no bypass) and fills the ID/EX register.
module mips32_decode (
  input  logic           clk,
  input  logic           reset,
  mips32_decode_if.slave bus
);
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_dst;
  logic        w_use_rs;
  logic        w_use_rt;
  logic        w_writes;
  logic        w_we;
  logic        w_hazard;
  logic        w_in_ready;
  logic        w_issue;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_busy_nxt;

  logic [31:0] r_busy;
  logic        r_out_valid;
  logic [5:0]  r_out_op;
  logic [5:0]  r_out_funct;
  logic [31:0] r_out_a;
  logic [31:0] r_out_b;
  logic [31:0] r_out_imm;
  logic [4:0]  r_out_dr;
  logic        r_out_we;
  logic [15:0] r_stall_cnt;

  assign w_op    = bus.instr[31:26];
  assign w_rs    = bus.instr[25:21];
  assign w_rt    = bus.instr[20:16];
  assign w_rd    = bus.instr[15:11];
  assign bus.sr1 = w_rs;
  assign bus.sr2 = w_rt;

  // Opcode class: which sources are read and which register is written
  always_comb begin
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_writes = 1'b0;
    w_dst    = 5'd0;
    casez (w_op)
      6'b000000: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_writes = 1'b1;
        w_dst    = w_rd;
      end
      6'b001???, 6'b100011: begin
        w_use_rs = 1'b1;
        w_writes = 1'b1;
        w_dst    = w_rt;
      end
      6'b101011, 6'b000100: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      default: begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_writes = 1'b0;
        w_dst    = 5'd0;
      end
    endcase
  end

  assign w_we       = w_writes && (w_dst != 5'd0);
  assign w_hazard   = bus.in_valid &&
                      ((w_use_rs && (w_rs != 5'd0) && r_busy[w_rs]) ||
                       (w_use_rt && (w_rt != 5'd0) && r_busy[w_rt]) ||
                       (w_we && r_busy[w_dst]));
  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard;
  assign w_issue    = bus.in_valid && w_in_ready;

  // Set is applied after clear so a same-cycle issue to the retiring register keeps it busy
  assign w_clr_mask = (bus.wb_valid && (bus.wb_dr != 5'd0)) ? (32'd1 << bus.wb_dr) : 32'd0;
  assign w_set_mask = (w_issue && w_we) ? (32'd1 << w_dst) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;

  // Scoreboard of registers with an outstanding write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // ID/EX register: load on issue, drain when execute consumes, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_op    <= 6'd0;
      r_out_funct <= 6'd0;
      r_out_a     <= 32'd0;
      r_out_b     <= 32'd0;
      r_out_imm   <= 32'd0;
      r_out_dr    <= 5'd0;
      r_out_we    <= 1'b0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out_op    <= w_op;
      r_out_funct <= bus.instr[5:0];
      r_out_a     <= bus.rddata1;
      r_out_b     <= bus.rddata2;
      r_out_imm   <= {{16{bus.instr[15]}}, bus.instr[15:0]};
      r_out_dr    <= w_dst;
      r_out_we    <= w_we;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Hazard-stall counter; backpressure alone never counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_op    = r_out_op;
  assign bus.out_funct = r_out_funct;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_imm   = r_out_imm;
  assign bus.out_dr    = r_out_dr;
  assign bus.out_we    = r_out_we;
  assign bus.stall_cnt = r_stall_cnt;
endmodule
